// File: rtl/chi_pkg.sv
// Shared opcodes, request payload and controller state for the CHI subordinate memory node.
package chi_pkg;

    localparam logic [3:0] CMD_READ     = 4'b0001;
    localparam logic [3:0] CMD_WRITE    = 4'b0010;
    localparam logic [3:0] RSP_COMPDATA = 4'b1001;
    localparam logic [3:0] RSP_COMP     = 4'b1010;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  cmd;
        logic [31:0] wdata;
    } req_t;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StWait,
        StResp
    } state_e;

endpackage

// File: rtl/chi_sn_mem_ctrl_if.sv
// Request/response channel between an upstream home node (master) and the memory node (slave).
interface chi_sn_mem_ctrl_if;

    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [3:0]  req_cmd;
    logic [31:0] req_wdata;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [3:0]  rsp_cmd;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_addr, req_cmd, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_cmd, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, req_cmd, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_cmd, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/chi_req_fifo.sv
// In-order request queue; full/empty derive only from the registered occupancy count.
module chi_req_fifo #(
    parameter type         T     = chi_pkg::req_t,
    parameter int unsigned DEPTH = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic push,
    input  T     push_data,
    input  logic pop,
    output T     pop_data,
    output logic full,
    output logic empty
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    T              mem_q [DEPTH];
    logic [PW-1:0] wptr_q;
    logic [PW-1:0] rptr_q;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem_q[rptr_q];

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (do_pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (!do_push && do_pop) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/chi_sn_mem_ctrl.sv
// Subordinate memory node: queues requests, serves one at a time from a word memory and
// returns a single registered response per request.
module chi_sn_mem_ctrl
    import chi_pkg::*;
#(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned MEM_WORDS = 256,
    parameter int unsigned RD_LAT    = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    chi_sn_mem_ctrl_if.slave        bus,
    output logic                    busy
);

    localparam int unsigned AW        = $clog2(MEM_WORDS);
    localparam int unsigned LW        = (RD_LAT > 2) ? $clog2(RD_LAT) : 1;
    localparam logic [31:0] BYTE_SPAN = 32'(4 * MEM_WORDS);

    state_e          state_q;
    req_t            req_q;
    req_t            head;
    logic [LW-1:0]   lat_q;
    logic            ready_en_q;
    logic            rsp_valid_q;
    logic [3:0]      rsp_cmd_q;
    logic [31:0]     rsp_rdata_q;
    logic            rsp_err_q;
    logic [31:0]     mem_q [MEM_WORDS];

    logic            fifo_full;
    logic            fifo_empty;
    logic            fifo_push;
    logic            fifo_pop;
    logic            is_read;
    logic            is_write;
    logic            req_legal;
    logic [AW-1:0]   word_idx;

    // Held low through reset and released by the first clock edge afterwards.
    assign bus.req_ready = ready_en_q && !fifo_full;
    assign fifo_push     = bus.req_valid && bus.req_ready;
    assign fifo_pop      = (state_q == StIdle) && !fifo_empty;

    chi_req_fifo #(
        .T     (req_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (fifo_push),
        .push_data ('{addr: bus.req_addr, cmd: bus.req_cmd, wdata: bus.req_wdata}),
        .pop       (fifo_pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign is_read   = (req_q.cmd == CMD_READ);
    assign is_write  = (req_q.cmd == CMD_WRITE);
    assign req_legal = (is_read || is_write) && (req_q.addr[1:0] == 2'b00) &&
                       (req_q.addr < BYTE_SPAN);
    assign word_idx  = req_q.addr[AW+1:2];

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_cmd   = rsp_cmd_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign busy          = !fifo_empty || (state_q != StIdle);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            req_q       <= '0;
            lat_q       <= '0;
            ready_en_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_cmd_q   <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
            unique case (state_q)
                StIdle: begin
                    if (!fifo_empty) begin
                        req_q   <= head;
                        state_q <= StAccess;
                    end
                end
                StAccess: begin
                    rsp_err_q   <= !req_legal;
                    rsp_cmd_q   <= (req_legal && is_read) ? RSP_COMPDATA : RSP_COMP;
                    rsp_rdata_q <= (req_legal && is_read) ? mem_q[word_idx] : '0;
                    if (!req_legal || !is_read || (RD_LAT == 1)) begin
                        state_q     <= StResp;
                        rsp_valid_q <= 1'b1;
                    end else begin
                        // WAIT spans RD_LAT-1 cycles: load RD_LAT-2 and exit on zero.
                        state_q <= StWait;
                        lat_q   <= LW'(RD_LAT - 2);
                    end
                end
                StWait: begin
                    if (lat_q == '0) begin
                        state_q     <= StResp;
                        rsp_valid_q <= 1'b1;
                    end else begin
                        lat_q <= lat_q - 1'b1;
                    end
                end
                StResp: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(MEM_WORDS); i++) begin
                mem_q[i] <= '0;
            end
        end else if ((state_q == StAccess) && req_legal && is_write) begin
            mem_q[word_idx] <= req_q.wdata;
        end
    end

endmodule

// File: tb/tb_chi_sn_mem_ctrl.sv
// Directed bench: RD_LAT=2 instance carries all functional checks, an RD_LAT=1 twin shares the
// request stream and is used for latency and data comparison only.
module tb_chi_sn_mem_ctrl;
    import chi_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic [31:0] req_addr;
    logic [3:0]  req_cmd;
    logic [31:0] req_wdata;
    logic        rsp_ready;
    logic        busy0;
    logic        busy1;
    int          n_checks = 0;
    int          n_fails  = 0;

    always #5 clk = ~clk;

    chi_sn_mem_ctrl_if bus0 ();
    chi_sn_mem_ctrl_if bus1 ();

    assign bus0.req_valid = req_valid;
    assign bus0.req_addr  = req_addr;
    assign bus0.req_cmd   = req_cmd;
    assign bus0.req_wdata = req_wdata;
    assign bus0.rsp_ready = rsp_ready;
    assign bus1.req_valid = req_valid;
    assign bus1.req_addr  = req_addr;
    assign bus1.req_cmd   = req_cmd;
    assign bus1.req_wdata = req_wdata;
    assign bus1.rsp_ready = 1'b1;

    chi_sn_mem_ctrl #(.DEPTH(4), .MEM_WORDS(256), .RD_LAT(2)) dut0 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus0),
        .busy    (busy0)
    );

    chi_sn_mem_ctrl #(.DEPTH(4), .MEM_WORDS(256), .RD_LAT(1)) dut1 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus1),
        .busy    (busy1)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after acceptance.
    task automatic push(input logic [3:0] cmd, input logic [31:0] addr, input logic [31:0] wdata);
        int n = 0;
        req_valid = 1'b1;
        req_cmd   = cmd;
        req_addr  = addr;
        req_wdata = wdata;
        while (!bus0.req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check_eq("push_timeout", 32'(bus0.req_ready), 32'd1);
        else @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic get_rsp(input string tag, input logic [3:0] cmd, input logic [31:0] rdata,
                           input logic err);
        int n = 0;
        rsp_ready = 1'b1;
        while (!bus0.rsp_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_valid"}, 32'(bus0.rsp_valid), 32'd1);
        check_eq({tag, "_cmd"}, 32'(bus0.rsp_cmd), 32'(cmd));
        check_eq({tag, "_rdata"}, bus0.rsp_rdata, rdata);
        check_eq({tag, "_err"}, 32'(bus0.rsp_err), 32'(err));
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy0 || busy1) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check_eq("idle_timeout", 32'(busy0 || busy1), 32'd0);
    endtask

    // Edges from acceptance to first rsp_valid, for both instances.
    task automatic lat_check(input string tag, input logic [3:0] cmd, input logic [31:0] addr,
                             input logic [31:0] wdata, input int exp0, input int exp1,
                             input logic [31:0] exp_rdata);
        int l0 = 0;
        int l1 = 0;
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_cmd   = cmd;
        req_addr  = addr;
        req_wdata = wdata;
        check_eq({tag, "_ready"}, 32'(bus0.req_ready && bus1.req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            if (bus0.rsp_valid && l0 == 0) l0 = k;
            if (bus1.rsp_valid && l1 == 0) l1 = k;
        end
        check_eq({tag, "_lat_rdlat2"}, l0, exp0);
        check_eq({tag, "_lat_rdlat1"}, l1, exp1);
        check_eq({tag, "_rdata_rdlat2"}, bus0.rsp_rdata, exp_rdata);
        check_eq({tag, "_rdata_rdlat1"}, bus1.rsp_rdata, exp_rdata);
        @(negedge clk);
        rsp_ready = 1'b0;
        wait_idle();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int accepted;
        int n;
        req_valid = 1'b0;
        req_cmd   = '0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b0;
        reset_n   = 1'b0;
        repeat (2) @(negedge clk);

        check_eq("rst_req_ready", 32'(bus0.req_ready), 32'd0);
        check_eq("rst_rsp_valid", 32'(bus0.rsp_valid), 32'd0);
        check_eq("rst_busy", 32'(busy0), 32'd0);
        check_eq("rst_rsp_cmd", 32'(bus0.rsp_cmd), 32'd0);
        check_eq("rst_rsp_rdata", bus0.rsp_rdata, 32'd0);
        check_eq("rst_rsp_err", 32'(bus0.rsp_err), 32'd0);

        reset_n = 1'b1;
        @(posedge clk);
        #1 check_eq("post_rst_ready", 32'(bus0.req_ready), 32'd1);
        @(negedge clk);

        push(CMD_READ, 32'h20, 32'h0);
        get_rsp("rd20_after_rst", RSP_COMPDATA, 32'h0, 1'b0);
        wait_idle();

        lat_check("lat_wr", CMD_WRITE, 32'h40, 32'h5A5A_0001, 2, 2, 32'h0);
        lat_check("lat_rd_a", CMD_READ, 32'h40, 32'h0, 3, 2, 32'h5A5A_0001);
        lat_check("lat_rd_b", CMD_READ, 32'h40, 32'h0, 3, 2, 32'h5A5A_0001);

        push(CMD_WRITE, 32'h10, 32'hABCD_1234);
        get_rsp("wr10", RSP_COMP, 32'h0, 1'b0);
        push(CMD_READ, 32'h10, 32'h0);
        get_rsp("rd10", RSP_COMPDATA, 32'hABCD_1234, 1'b0);

        push(CMD_READ, 32'h11, 32'h0);
        get_rsp("rd_misaligned", RSP_COMP, 32'h0, 1'b1);
        push(CMD_READ, 32'h400, 32'h0);
        get_rsp("rd_range", RSP_COMP, 32'h0, 1'b1);
        push(4'h7, 32'h10, 32'h1111_1111);
        get_rsp("bad_cmd", RSP_COMP, 32'h0, 1'b1);
        push(CMD_WRITE, 32'h400, 32'hDEAD_BEEF);
        get_rsp("wr_range", RSP_COMP, 32'h0, 1'b1);
        push(CMD_WRITE, 32'h12, 32'hDEAD_BEEF);
        get_rsp("wr_misaligned", RSP_COMP, 32'h0, 1'b1);
        push(CMD_READ, 32'h10, 32'h0);
        get_rsp("rd10_kept", RSP_COMPDATA, 32'hABCD_1234, 1'b0);
        push(CMD_READ, 32'h0, 32'h0);
        get_rsp("rd0_kept", RSP_COMPDATA, 32'h0, 1'b0);
        wait_idle();

        for (int i = 0; i < 6; i++) begin
            push(CMD_WRITE, 32'h100 + 32'(4 * i), 32'hC0DE_0000 + 32'(i));
            get_rsp($sformatf("prewr%0d", i), RSP_COMP, 32'h0, 1'b0);
        end
        wait_idle();

        // Backpressure: one in flight plus DEPTH queued, then the sixth must stall.
        accepted  = 0;
        req_valid = 1'b1;
        req_cmd   = CMD_READ;
        req_addr  = 32'h100;
        for (int c = 0; c < 20; c++) begin
            if (bus0.req_ready && accepted < 6) begin
                @(posedge clk);
                accepted++;
                @(negedge clk);
                req_addr = 32'h100 + 32'(4 * accepted);
            end else begin
                @(negedge clk);
            end
        end
        check_eq("fill_accepted", 32'(accepted), 32'd5);
        check_eq("fill_ready", 32'(bus0.req_ready), 32'd0);
        check_eq("fill_count", 32'(dut0.u_fifo.count_q), 32'd4);
        get_rsp("ord0", RSP_COMPDATA, 32'hC0DE_0000, 1'b0);
        n = 0;
        while (!bus0.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("sixth_ready", 32'(bus0.req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 1; i < 6; i++) begin
            get_rsp($sformatf("ord%0d", i), RSP_COMPDATA, 32'hC0DE_0000 + 32'(i), 1'b0);
        end
        wait_idle();

        // Reset while in WAIT with three requests queued.
        for (int i = 0; i < 5; i++) push(CMD_READ, 32'h100 + 32'(4 * i), 32'h0);
        rsp_ready = 1'b1;
        n = 0;
        while (!bus0.rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_eq("pre_rst_wait", 32'(dut0.state_q), 32'(StWait));
        check_eq("pre_rst_count", 32'(dut0.u_fifo.count_q), 32'd3);
        reset_n = 1'b0;
        #1;
        check_eq("mid_rst_valid", 32'(bus0.rsp_valid), 32'd0);
        check_eq("mid_rst_busy", 32'(busy0), 32'd0);
        check_eq("mid_rst_ready", 32'(bus0.req_ready), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("post_rst_valid", 32'(bus0.rsp_valid), 32'd0);
        check_eq("post_rst_busy", 32'(busy0), 32'd0);
        check_eq("post_rst_count", 32'(dut0.u_fifo.count_q), 32'd0);
        check_eq("post_rst_ready2", 32'(bus0.req_ready), 32'd1);
        push(CMD_READ, 32'h10, 32'h0);
        get_rsp("rd10_cleared", RSP_COMPDATA, 32'h0, 1'b0);
        push(CMD_READ, 32'h104, 32'h0);
        get_rsp("rd104_cleared", RSP_COMPDATA, 32'h0, 1'b0);
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/chi_sn_mem_ctrl.md
CHI_SN_MEM_CTRL -- requirements
Module: chi_sn_mem_ctrl

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning request-queue entries (power of two, minimum 2).
REQ-002 The block SHALL have parameter MEM_WORDS, default 256, meaning 32-bit memory words; the byte span is 4*MEM_WORDS.
REQ-003 The block SHALL have parameter RD_LAT, default 2, meaning cycles from ACCESS to read response (minimum 1).
REQ-004 clk  input  1  the single clock; all state SHALL be updated on its rising edge.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 req_valid  input  1  a request from the upstream home node is present.
REQ-007 req_ready  output  1  the queue can accept a request this cycle.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_cmd  input  4  opcode: 4'b0001 read, 4'b0010 write.
REQ-010 req_wdata  input  32  write data.
REQ-011 rsp_valid  output  1  a response is presented.
REQ-012 rsp_ready  input  1  the upstream consumer accepts the response.
REQ-013 rsp_cmd  output  4  4'b1001 CompData (read), 4'b1010 Comp (write or error).
REQ-014 rsp_rdata  output  32  read data; 0 for a write or an error.
REQ-015 rsp_err  output  1  the request was illegal and had no effect.
REQ-016 busy  output  1  the queue is non-empty or the FSM is not IDLE.

Function
REQ-017 A request SHALL be accepted on a rising edge where req_valid && req_ready; req_ready SHALL equal !full, computed from registered state only.
REQ-018 The queue SHALL be in-order FIFO storage of {addr, cmd, wdata}, with read/write pointers that wrap modulo DEPTH and a count of 0..DEPTH.
REQ-019 When full, req_ready SHALL be 0 even if a pop occurs in the same cycle; a push and a pop in the same cycle when not full SHALL leave count unchanged.
REQ-020 The FSM SHALL have states IDLE, ACCESS, WAIT and RESP.
REQ-021 IDLE->ACCESS SHALL occur when the queue is non-empty, popping the head into a request register on that edge.
REQ-022 In ACCESS, a legal write SHALL update the memory, and a legal read SHALL capture the memory word.
REQ-023 ACCESS->RESP SHALL occur for a write, an illegal request, or RD_LAT==1; otherwise ACCESS->WAIT.
REQ-024 WAIT SHALL count RD_LAT-1 cycles using a down-counter, then go to RESP.
REQ-025 RESP SHALL drive rsp_valid=1 with stable rsp_cmd, rsp_rdata and rsp_err until rsp_valid && rsp_ready, then go to IDLE.
REQ-026 In RESP, the head SHALL NOT be popped early; one transaction is outstanding at a time.
REQ-027 A request SHALL be illegal when req_cmd is not 0001/0010, req_addr[1:0]!=0, or req_addr>=4*MEM_WORDS; an illegal request SHALL give rsp_err=1, rsp_cmd=1010 and rsp_rdata=0, with no memory change.
REQ-028 The memory word index SHALL be req_addr[$clog2(MEM_WORDS)+1:2].
REQ-029 Latency with an empty queue and rsp_ready=1 SHALL be: write rsp_valid first high after the 2nd edge following acceptance; read after the (1+RD_LAT)th edge.
REQ-030 Requests SHALL complete in acceptance order, so a read after a write to the same address returns the written data.

Reset
REQ-031 While reset_n=0, the FSM SHALL be IDLE, pointers and count 0, and all memory words 0.
REQ-032 While reset_n=0, rsp_valid, rsp_err and busy SHALL be 0, rsp_cmd and rsp_rdata 0, and req_ready 0.
REQ-033 req_ready SHALL be 1 from the first edge after reset_n rises.
REQ-034 Reset asserted mid-transaction SHALL discard all queued and in-flight requests with no response.

Structure
REQ-035 Package chi_pkg SHALL hold the opcode constants (CMD_READ, CMD_WRITE, RSP_COMPDATA, RSP_COMP), the request struct {addr, cmd, wdata} and the FSM state enum.
REQ-036 The queue SHALL be the sub-module chi_req_fifo, parameterised by DEPTH and the payload type.

Verification
REQ-037 Write 0x10/0xABCD1234, then read 0x10 -> Comp, err=0, then CompData rdata=0xABCD1234, err=0.
REQ-038 Hold rsp_ready=0 and push 6 requests -> req_ready drops after 4 queued plus 1 in flight; no loss or reorder after release.
REQ-039 Read 0x11 (misaligned), read 0x400 (out of range), cmd 0x7 -> three Comp responses with err=1 and memory unchanged.
REQ-040 Back-to-back reads with rsp_ready=1 -> read latency of exactly 1+RD_LAT edges, checked for RD_LAT=1 and 2.
REQ-041 Read 0x20 after reset -> rdata=0.
REQ-042 Assert reset_n=0 while in WAIT with 3 queued -> no rsp_valid, busy=0 and count=0 after release.
